// File: rtl/shift_unit_pkg.sv
// Shared definitions for the multi-cycle shifter: operation codes and FSM states.
package shift_pkg;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_unit_if.sv
// Request/result bundle between the ALU sequencer (master) and the shifter (slave).
interface shift_unit_if #(
  parameter int WIDTH = 8
);
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] d_in;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d_out;
  logic             carry;
  logic             zero;

  modport master (
    output start, op, d_in, shamt,
    input  busy, done, d_out, carry, zero
  );

  modport slave (
    input  start, op, d_in, shamt,
    output busy, done, d_out, carry, zero
  );

endinterface

// File: rtl/shift_step.sv
// One shifter iteration: moves a word by k (0..STEP) places for the given op.
// Each result bit is a (STEP+1):1 mux over the candidate source bits.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0]             work,
  input  logic [1:0]                   op,
  input  logic [$clog2(STEP+1)-1:0]    k,
  output logic [WIDTH-1:0]             res,
  output logic                         out_bit
);

  genvar gi, gj;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [STEP:0] col;
      for (gj = 0; gj <= STEP; gj++) begin : g_amt
        logic lsl_b, lsr_b, asr_b, ror_b;
        if (gi >= gj) begin : g_lsl_in
          assign lsl_b = work[gi-gj];
        end else begin : g_lsl_fill
          assign lsl_b = 1'b0;
        end
        // Right shifts past the top take zero (LSR) or the sign bit (ASR).
        if (gi + gj < WIDTH) begin : g_rs_in
          assign lsr_b = work[gi+gj];
          assign asr_b = work[gi+gj];
        end else begin : g_rs_fill
          assign lsr_b = 1'b0;
          assign asr_b = work[WIDTH-1];
        end
        assign ror_b = work[(gi+gj) % WIDTH];
        assign col[gj] = (op == OP_LSL) ? lsl_b :
                         (op == OP_LSR) ? lsr_b :
                         (op == OP_ASR) ? asr_b : ror_b;
      end
      assign res[gi] = col[k];
    end
  endgenerate

  logic [STEP:0] ob;
  assign ob[0] = 1'b0;

  generate
    for (gj = 1; gj <= STEP; gj++) begin : g_out
      // The last bit leaving the word: top side for LSL, bottom side otherwise.
      assign ob[gj] = (op == OP_LSL) ? work[WIDTH-gj] : work[gj-1];
    end
  endgenerate

  assign out_bit = ob[k];

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter: LSL/LSR/ASR/ROR, up to STEP places per clock, with a
// start/busy/done handshake and registered result, carry and zero flags.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic       clk,
  input  logic       reset,
  shift_unit_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int KW  = $clog2(STEP+1);
  localparam logic [SHW:0] STEP_EXT = (SHW+1)'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic             carry_w_q, carry_w_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic [SHW:0]     rem_ext, k_full;
  logic [KW-1:0]    k;
  logic             last_step, accept, load_out;
  logic [WIDTH-1:0] step_res;
  logic             step_out;

  assign rem_ext   = {1'b0, rem_q};
  assign k_full    = (rem_ext < STEP_EXT) ? rem_ext : STEP_EXT;
  assign k         = KW'(k_full);
  assign last_step = (rem_ext <= STEP_EXT);
  assign accept    = (state_q == S_IDLE) && bus.start;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .work    (work_q),
    .op      (op_q),
    .k       (k),
    .res     (step_res),
    .out_bit (step_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (bus.shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_step) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state_q != S_IDLE);
    bus.done  = (state_q == S_DONE);
    bus.d_out = d_out_q;
    bus.carry = carry_q;
    bus.zero  = zero_q;
  end

  // Result registers load only on the transition into DONE, from the value
  // the work register is receiving on that same edge.
  assign load_out = (state_d == S_DONE) && (state_q != S_DONE);

  always_comb begin
    work_d    = work_q;
    rem_d     = rem_q;
    op_d      = op_q;
    carry_w_d = carry_w_q;
    if (accept) begin
      work_d    = bus.d_in;
      rem_d     = bus.shamt;
      op_d      = bus.op;
      carry_w_d = 1'b0;
    end else if (state_q == S_SHIFT) begin
      work_d    = step_res;
      rem_d     = rem_q - SHW'(k_full);
      carry_w_d = step_out;
    end
  end

  always_comb begin
    d_out_d = d_out_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (load_out) begin
      d_out_d = work_d;
      carry_d = carry_w_d;
      zero_d  = (work_d == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q    <= '0;
      rem_q     <= '0;
      op_q      <= OP_LSL;
      carry_w_q <= 1'b0;
      d_out_q   <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      work_q    <= work_d;
      rem_q     <= rem_d;
      op_q      <= op_d;
      carry_w_q <= carry_w_d;
      d_out_q   <= d_out_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench: a STEP=1 and a STEP=4 shifter side by side, checked
// against an arithmetic reference model and directed expected values.
module tb_shift_unit;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_unit_if #(.WIDTH(8)) bus1 ();
  shift_unit_if #(.WIDTH(8)) bus4 ();

  shift_unit #(.WIDTH(8), .STEP(1)) u_s1 (.clk(clk), .reset(reset), .bus(bus1));
  shift_unit #(.WIDTH(8), .STEP(4)) u_s4 (.clk(clk), .reset(reset), .bus(bus4));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: whole shift by n in one go, carry = last bit that left the word.
  function automatic logic [8:0] ref_shift(input logic [1:0] op, input logic [7:0] d, input int n);
    int u, s, r, c;
    u = int'(d);
    s = (u >= 128) ? u - 256 : u;
    if (n == 0) return {1'b0, d};
    case (op)
      OP_LSL:  begin r = (u << n) & 255;                  c = (u >> (8 - n)) & 1; end
      OP_LSR:  begin r = u >> n;                          c = (u >> (n - 1)) & 1; end
      OP_ASR:  begin r = (s >>> n) & 255;                 c = (u >> (n - 1)) & 1; end
      default: begin r = ((u >> n) | (u << (8 - n))) & 255; c = (u >> (n - 1)) & 1; end
    endcase
    return {c[0], r[7:0]};
  endfunction

  task automatic drive(input int which, input logic s, input logic [1:0] op,
                       input logic [7:0] d, input logic [2:0] sh);
    if (which == 1) begin
      bus1.start = s; bus1.op = op; bus1.d_in = d; bus1.shamt = sh;
    end else begin
      bus4.start = s; bus4.op = op; bus4.d_in = d; bus4.shamt = sh;
    end
  endtask

  task automatic sample(input int which, output logic busy, output logic done,
                        output logic [7:0] dout, output logic carry, output logic zero);
    if (which == 1) begin
      busy = bus1.busy; done = bus1.done; dout = bus1.d_out; carry = bus1.carry; zero = bus1.zero;
    end else begin
      busy = bus4.busy; done = bus4.done; dout = bus4.d_out; carry = bus4.carry; zero = bus4.zero;
    end
  endtask

  // Issue one request; lat = edges after the accepting edge until done is seen.
  task automatic do_op(input int which, input logic [1:0] op, input logic [7:0] d,
                       input logic [2:0] sh, output logic [7:0] dout, output logic carry,
                       output logic zero, output int lat, output logic done_after);
    logic b, dn;
    @(negedge clk);
    drive(which, 1'b1, op, d, sh);
    @(posedge clk); #1;
    drive(which, 1'b0, ~op, ~d, ~sh);
    lat = 0;
    sample(which, b, dn, dout, carry, zero);
    while (!dn && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      sample(which, b, dn, dout, carry, zero);
    end
    @(posedge clk); #1;
    sample(which, b, done_after, d, d, d[0]);
    $display("step%0d op=%0d d_in=%02h shamt=%0d -> d_out=%02h carry=%0b zero=%0b lat=%0d",
             which, op, d, sh, dout, carry, zero, lat);
  endtask

  task automatic test_reset();
    logic b, dn, c, z;
    logic [7:0] o;
    reset = 1'b1;
    drive(1, 1'b0, 2'b00, 8'h00, 3'd0);
    drive(4, 1'b0, 2'b00, 8'h00, 3'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int w = 1; w <= 4; w += 3) begin
      sample(w, b, dn, o, c, z);
      n_cmp += 5;
      if (b !== 1'b0)  begin n_bad++; $display("FAIL reset_busy step%0d got %b want 0", w, b); end
      if (dn !== 1'b0) begin n_bad++; $display("FAIL reset_done step%0d got %b want 0", w, dn); end
      if (o !== 8'h00) begin n_bad++; $display("FAIL reset_dout step%0d got %h want 00", w, o); end
      if (c !== 1'b0)  begin n_bad++; $display("FAIL reset_carry step%0d got %b want 0", w, c); end
      if (z !== 1'b1)  begin n_bad++; $display("FAIL reset_zero step%0d got %b want 1", w, z); end
    end
  endtask

  task automatic test_directed();
    logic [1:0] ops [5] = '{OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_LSL};
    logic [7:0] din [5] = '{8'hB5, 8'hB5, 8'h85, 8'hB5, 8'h80};
    logic [2:0] shs [5] = '{3'd3, 3'd2, 3'd7, 3'd4, 3'd1};
    logic [7:0] eo  [5] = '{8'hA8, 8'h2D, 8'hFF, 8'h5B, 8'h00};
    logic       ec  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ez  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] o;
    logic c, z, da;
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(1, ops[i], din[i], shs[i], o, c, z, lat, da);
      n_cmp += 5;
      if (o !== eo[i])        begin n_bad++; $display("FAIL dir_dout #%0d got %h want %h", i, o, eo[i]); end
      if (c !== ec[i])        begin n_bad++; $display("FAIL dir_carry #%0d got %b want %b", i, c, ec[i]); end
      if (z !== ez[i])        begin n_bad++; $display("FAIL dir_zero #%0d got %b want %b", i, z, ez[i]); end
      if (lat != int'(shs[i])) begin n_bad++; $display("FAIL dir_latency #%0d got %0d want %0d", i, lat, shs[i]); end
      if (da !== 1'b0)        begin n_bad++; $display("FAIL dir_done_pulse #%0d done still high", i); end
    end
  endtask

  task automatic test_busy_window();
    logic b, dn, c, z;
    logic [7:0] o;
    int busy_cnt = 0, done_cnt = 0, done_at = -1;
    @(negedge clk);
    drive(1, 1'b1, OP_LSL, 8'hB5, 3'd3);
    @(posedge clk); #1;
    drive(1, 1'b0, OP_LSL, 8'hB5, 3'd3);
    for (int e = 0; e < 8; e++) begin
      sample(1, b, dn, o, c, z);
      if (b === 1'b1) busy_cnt++;
      if (dn === 1'b1) begin done_cnt++; done_at = e; end
      @(posedge clk); #1;
    end
    n_cmp += 3;
    if (busy_cnt != 4) begin n_bad++; $display("FAIL busy_cycles got %0d want 4", busy_cnt); end
    if (done_cnt != 1) begin n_bad++; $display("FAIL busy_done_count got %0d want 1", done_cnt); end
    if (done_at != 3)  begin n_bad++; $display("FAIL busy_done_cycle got %0d want 3", done_at); end
  endtask

  task automatic test_zero_shift();
    logic [7:0] o;
    logic c, z, da;
    int lat;
    for (int w = 1; w <= 4; w += 3) begin
      for (int op = 0; op < 4; op++) begin
        do_op(w, 2'(op), 8'h3C, 3'd0, o, c, z, lat, da);
        n_cmp += 4;
        if (o !== 8'h3C) begin n_bad++; $display("FAIL zsh_dout step%0d op%0d got %h want 3c", w, op, o); end
        if (c !== 1'b0)  begin n_bad++; $display("FAIL zsh_carry step%0d op%0d got %b want 0", w, op, c); end
        if (lat != 0)    begin n_bad++; $display("FAIL zsh_latency step%0d op%0d got %0d want 0", w, op, lat); end
        if (da !== 1'b0) begin n_bad++; $display("FAIL zsh_done_pulse step%0d op%0d", w, op); end
      end
    end
  endtask

  task automatic test_step4_ignore();
    logic b, dn, c, z;
    logic [7:0] o;
    int lat, extra_done;
    @(negedge clk);
    drive(4, 1'b1, OP_LSL, 8'h01, 3'd7);
    @(posedge clk); #1;
    drive(4, 1'b1, OP_LSL, 8'hFF, 3'd7);
    lat = 0;
    sample(4, b, dn, o, c, z);
    while (!dn && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      sample(4, b, dn, o, c, z);
    end
    $display("step4 ignore-start run: d_out=%02h lat=%0d", o, lat);
    n_cmp += 2;
    if (lat != 2)    begin n_bad++; $display("FAIL s4_latency got %0d want 2", lat); end
    if (o !== 8'h80) begin n_bad++; $display("FAIL s4_dout got %h want 80", o); end
    @(posedge clk); #1;
    drive(4, 1'b0, OP_LSL, 8'hFF, 3'd7);
    sample(4, b, dn, o, c, z);
    n_cmp++;
    if (b !== 1'b0) begin n_bad++; $display("FAIL s4_idle_after got busy=%b want 0", b); end
    extra_done = 0;
    repeat (4) begin
      @(posedge clk); #1;
      sample(4, b, dn, o, c, z);
      if (dn !== 1'b0) extra_done++;
    end
    n_cmp += 2;
    if (extra_done != 0) begin n_bad++; $display("FAIL s4_ignored_start got %0d extra done want 0", extra_done); end
    if (o !== 8'h80)     begin n_bad++; $display("FAIL s4_hold got %h want 80", o); end
  endtask

  task automatic test_reset_mid();
    logic b, dn, c, z, da;
    logic [7:0] o;
    int lat, stray;
    do_op(1, OP_ROR, 8'hB5, 3'd4, o, c, z, lat, da);
    @(negedge clk);
    drive(1, 1'b1, OP_LSL, 8'hFF, 3'd6);
    @(posedge clk); #1;
    drive(1, 1'b0, OP_LSL, 8'hFF, 3'd6);
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    sample(1, b, dn, o, c, z);
    n_cmp += 4;
    if (b !== 1'b0)  begin n_bad++; $display("FAIL rmid_busy got %b want 0", b); end
    if (o !== 8'h00) begin n_bad++; $display("FAIL rmid_dout got %h want 00", o); end
    if (z !== 1'b1)  begin n_bad++; $display("FAIL rmid_zero got %b want 1", z); end
    if (dn !== 1'b0) begin n_bad++; $display("FAIL rmid_done got %b want 0", dn); end
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (10) begin
      @(posedge clk); #1;
      sample(1, b, dn, o, c, z);
      if (dn !== 1'b0 || b !== 1'b0) stray++;
    end
    n_cmp++;
    if (stray != 0) begin n_bad++; $display("FAIL rmid_no_done got %0d active cycles want 0", stray); end
    do_op(1, OP_LSR, 8'hF0, 3'd4, o, c, z, lat, da);
    n_cmp += 3;
    if (o !== 8'h0F) begin n_bad++; $display("FAIL rmid_after_dout got %h want 0f", o); end
    if (c !== 1'b0)  begin n_bad++; $display("FAIL rmid_after_carry got %b want 0", c); end
    if (lat != 4)    begin n_bad++; $display("FAIL rmid_after_latency got %0d want 4", lat); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] o;
    logic c, z, da;
    int lat;
    do_op(4, OP_ASR, 8'h90, 3'd5, o, c, z, lat, da);
    n_cmp += 4;
    if (o !== 8'hFC) begin n_bad++; $display("FAIL b2b_first_dout got %h want fc", o); end
    if (c !== 1'b1)  begin n_bad++; $display("FAIL b2b_first_carry got %b want 1", c); end
    if (lat != 2)    begin n_bad++; $display("FAIL b2b_first_latency got %0d want 2", lat); end
    if (da !== 1'b0) begin n_bad++; $display("FAIL b2b_first_done_pulse"); end
    do_op(4, OP_ROR, 8'h01, 3'd1, o, c, z, lat, da);
    n_cmp += 4;
    if (o !== 8'h80) begin n_bad++; $display("FAIL b2b_second_dout got %h want 80", o); end
    if (c !== 1'b1)  begin n_bad++; $display("FAIL b2b_second_carry got %b want 1", c); end
    if (lat != 1)    begin n_bad++; $display("FAIL b2b_second_latency got %0d want 1", lat); end
    if (da !== 1'b0) begin n_bad++; $display("FAIL b2b_second_done_pulse"); end
  endtask

  task automatic test_random();
    logic [7:0] o, d;
    logic [1:0] op;
    logic [2:0] sh;
    logic [8:0] exp_v;
    logic c, z, da;
    int lat, w, step, exp_lat;
    for (int i = 0; i < 60; i++) begin
      w  = ($urandom_range(0, 1) == 0) ? 1 : 4;
      step = w;
      op = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      sh = 3'($urandom_range(0, 7));
      exp_v   = ref_shift(op, d, int'(sh));
      exp_lat = (int'(sh) + step - 1) / step;
      do_op(w, op, d, sh, o, c, z, lat, da);
      n_cmp += 5;
      if (o !== exp_v[7:0])          begin n_bad++; $display("FAIL rnd_dout #%0d got %h want %h", i, o, exp_v[7:0]); end
      if (c !== exp_v[8])            begin n_bad++; $display("FAIL rnd_carry #%0d got %b want %b", i, c, exp_v[8]); end
      if (z !== (exp_v[7:0] == 8'h0)) begin n_bad++; $display("FAIL rnd_zero #%0d got %b want %b", i, z, exp_v[7:0] == 8'h0); end
      if (lat != exp_lat)            begin n_bad++; $display("FAIL rnd_latency #%0d got %0d want %0d", i, lat, exp_lat); end
      if (da !== 1'b0)               begin n_bad++; $display("FAIL rnd_done_pulse #%0d", i); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_window();
    test_zero_shift();
    test_step4_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
